divide: RTL and testbench
=========================

Name: divide

Overview:
- Iterative signed integer divider; the inverse of the team's pipelined signed multiply stage.
- Uses the same stb/rdy stream interface. Input is a packed operand pair; output is a packed {remainder, quotient} word.
- Sits in the arithmetic datapath beside the multiplier, so downstream stages can consume either unit.
- Not pipelined: one division in flight; restoring algorithm producing one quotient bit per cycle.

Parameters:
- W, 8, operand width in bits. Dividend, divisor, quotient and remainder are each W bits, signed two's complement. W >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_stb  in  1  source strobe: operand pair valid
- s_dat  in  2W  operands: s_dat[0+:W] = dividend, s_dat[W+:W] = divisor
- s_rdy  out  1  source ready
- m_rdy  in  1  sink ready
- m_stb  out  1  result valid
- m_dat  out  2W  result: m_dat[0+:W] = quotient, m_dat[W+:W] = remainder

Behaviour:
- Handshake:
  - Source transfer (s_ack) = s_stb & s_rdy. Sink transfer (m_ack) = m_stb & m_rdy.
  - s_stb, s_dat, m_rdy may change freely when no transfer occurs.
- Reset:
  - While rst is high: state=IDLE, m_stb=0, m_dat=0, iteration counter=0, s_rdy=0.
  - s_rdy=1 in the first cycle after rst deasserts.
  - rst mid-operation aborts the division; no result is ever presented for it.
- FSM:
  - IDLE: s_rdy=1, m_stb=0. On s_ack, latch the operands (dividend/divisor magnitudes, result signs, special-case flags), clear the partial remainder, set counter=W-1, go to CALC.
  - CALC: s_rdy=0, m_stb=0. Each cycle, run one restoring step:
    - shift the partial remainder left, bringing in the next dividend MSB;
    - trial-subtract the |divisor|; keep the difference if non-negative;
    - shift the quotient bit in; decrement the counter.
  - CALC exit: on the step with counter==0, register the signed-corrected result into m_dat, set m_stb=1, go to DONE.
  - DONE: s_rdy=0, m_stb=1, m_dat held stable. On m_ack, m_stb<=0, go to IDLE.
- Timing:
  - Latency: s_ack on edge N gives m_stb=1 after edge N+W.
  - Latency is constant, including special cases; they still run all W steps.
  - Throughput: one result per W+2 cycles with m_rdy held high.
- Arithmetic:
  - Truncating division (quotient rounds toward zero).
  - Remainder takes the sign of the dividend; |remainder| < |divisor|.
  - Magnitudes are computed in W bits unsigned, so |-2^(W-1)| = 2^(W-1) is representable.
  - Quotient is negated iff operand signs differ; remainder is negated iff the dividend is negative.
- Special cases (flags captured at accept):
  - Divisor==0: quotient = all ones (-1), remainder = dividend.
  - Dividend==-2^(W-1) and divisor==-1 (overflow): quotient = -2^(W-1), remainder = 0.
- Backpressure: m_rdy low in DONE holds m_stb and m_dat indefinitely; s_rdy stays low.
- m_rdy is ignored outside DONE.

Decomposition:
- Shared arithmetic package:
  - FSM state encoding: IDLE, CALC, DONE.
  - Operand field offsets (dividend/quotient at 0, divisor/remainder at W). The multiplier reuses these.
  - Special-case result constants as W-parametric functions (all-ones quotient, min-int).
- Natural sub-module: divide_step.
  - Purely combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: new partial remainder, quotient bit.
  - Unit-testable in isolation.

Test Plan (W=8):
- s_dat=16'h0764 (100/7), m_rdy=1 -> m_dat=16'h020E (q=14, r=2); m_stb rises exactly 8 edges after the accept edge and stays high for 1 cycle.
- Sign mix, m_rdy=1:
  - s_dat=16'h079C (-100/7) -> m_dat=16'hFEF2.
  - s_dat=16'hF964 (100/-7) -> m_dat=16'h02F2.
  - s_dat=16'hF99C (-100/-7) -> m_dat=16'hFE0E.
- Special cases, each still exactly 8-cycle latency:
  - s_dat=16'h0005 (5/0) -> m_dat=16'h05FF.
  - s_dat=16'hFF80 (-128/-1) -> m_dat=16'h0080.
  - s_dat=16'h0180 (-128/1) -> m_dat=16'h0080.
- Backpressure:
  - Hold m_rdy=0 for 5 cycles after m_stb rises -> m_stb=1 and m_dat constant throughout; s_rdy=0 and s_stb ignored.
  - Raise m_rdy -> one m_ack; s_rdy=1 the next cycle.
- Back-to-back with s_stb held high over random operand streams (m_rdy random):
  - each result matches the reference model;
  - accept-to-accept spacing is 10 cycles when m_rdy=1;
  - no operand is dropped or duplicated.
- Assert rst for 1 cycle at CALC step 4 of 100/7 -> no m_stb for that operation; s_rdy=1 the cycle after rst falls; next operation 9/2 returns 16'h0104.

Source files
------------

// File: rtl/divide_pkg.sv
// Shared arithmetic definitions for the divide and multiply datapath stages.
// Holds the FSM encoding, the packed operand/result field offsets and the special-case result constants.
package divide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Low field holds dividend/quotient; the high field, which starts at W, holds divisor/remainder.
    localparam int unsigned LO_OFS = 0;
    localparam int unsigned MAX_W  = 64;

    function automatic int unsigned hi_ofs(input int unsigned w);
        return w;
    endfunction

    // Special-case constants are returned MAX_W wide; callers narrow them with W'(...).
    function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
        return ~({MAX_W{1'b1}} << w);
    endfunction

    function automatic logic [MAX_W-1:0] min_int(input int unsigned w);
        return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring division iteration: shift in the next dividend bit, then trial-subtract |divisor|.
// Purely combinational; the extra top bit keeps the compare exact even for out-of-range partial remainders.
module divide_step #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next_c,
    output logic         q_bit_c
);

    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted    = {rem, bit_in};
        diff       = shifted - {1'b0, dvs};
        q_bit_c    = (shifted >= {1'b0, dvs});
        rem_next_c = q_bit_c ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/divide.sv
// Iterative signed restoring divider with a stb/rdy stream interface, one division in flight.
// A result is presented exactly W cycles after the operands are accepted, special cases included.
module divide
    import divide_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_stb,
    input  logic [2*W-1:0] s_dat,
    output logic           s_rdy,
    input  logic           m_rdy,
    output logic           m_stb,
    output logic [2*W-1:0] m_dat
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned HI = hi_ofs(W);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   dvd_sh;
    logic [W-1:0]   dvd_raw;
    logic [W-1:0]   dvs_mag;
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic           neg_q;
    logic           neg_r;
    logic           div0;
    logic           ovf;

    logic [W-1:0]   in_dvd;
    logic [W-1:0]   in_dvs;
    logic [W-1:0]   rem_next_c;
    logic           q_bit_c;
    logic [W-1:0]   quo_next;
    logic [W-1:0]   q_res;
    logic [W-1:0]   r_res;

    assign in_dvd = s_dat[LO_OFS +: W];
    assign in_dvs = s_dat[HI +: W];

    divide_step #(.W(W)) u_step (
        .rem        (rem),
        .bit_in     (dvd_sh[W-1]),
        .dvs        (dvs_mag),
        .rem_next_c (rem_next_c),
        .q_bit_c    (q_bit_c)
    );

    // Sign correction and special-case override of the final restoring step.
    always_comb begin
        quo_next = {quo[W-2:0], q_bit_c};
        q_res    = quo_next;
        r_res    = rem_next_c;
        if (div0) begin
            q_res = W'(all_ones(W));
            r_res = dvd_raw;
        end else if (ovf) begin
            q_res = W'(min_int(W));
            r_res = '0;
        end else begin
            if (neg_q) q_res = -quo_next;
            if (neg_r) r_res = -rem_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_rdy   <= 1'b0;
            m_stb   <= 1'b0;
            m_dat   <= '0;
            cnt     <= '0;
            dvd_sh  <= '0;
            dvd_raw <= '0;
            dvs_mag <= '0;
            rem     <= '0;
            quo     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m_stb <= 1'b0;
                    if (s_stb && s_rdy) begin
                        dvd_raw <= in_dvd;
                        dvd_sh  <= in_dvd[W-1] ? -in_dvd : in_dvd;
                        dvs_mag <= in_dvs[W-1] ? -in_dvs : in_dvs;
                        neg_q   <= in_dvd[W-1] ^ in_dvs[W-1];
                        neg_r   <= in_dvd[W-1];
                        div0    <= (in_dvs == '0);
                        ovf     <= (in_dvd == W'(min_int(W))) && (in_dvs == W'(all_ones(W)));
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= CW'(W - 1);
                        s_rdy   <= 1'b0;
                        state   <= CALC;
                    end else begin
                        s_rdy <= 1'b1;
                    end
                end
                CALC: begin
                    rem    <= rem_next_c;
                    quo    <= quo_next;
                    dvd_sh <= dvd_sh << 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0) begin
                        m_dat <= {r_res, q_res};
                        m_stb <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (m_rdy) begin
                        m_stb <= 1'b0;
                        s_rdy <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: a driver queues expected results at accept time, a monitor checks them.
// Directed vectors carry literal expectations; random streams use an integer-arithmetic reference.
module tb_divide;

    localparam int unsigned W = 8;

    typedef struct {
        logic [2*W-1:0] dat;
        int             acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_stb;
    logic [2*W-1:0] s_dat;
    logic           s_rdy;
    logic           m_rdy;
    logic           m_stb;
    logic [2*W-1:0] m_dat;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divide #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .m_rdy (m_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Truncating signed division straight from the arithmetic rules.
    function automatic logic [2*W-1:0] model(input logic [2*W-1:0] d);
        int a, b, q, r;
        a = $signed(d[W-1:0]);
        b = $signed(d[2*W-1:W]);
        if (b == 0) begin
            q = -1; r = a;
        end else if (a == -(2 ** (W - 1)) && b == -1) begin
            q = a; r = 0;
        end else begin
            q = a / b; r = a % b;
        end
        return {W'(r), W'(q)};
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: latency, pulse width, hold under backpressure and result data.
    logic           prev_stb = 1'b0;
    logic           prev_ack = 1'b0;
    logic [2*W-1:0] held;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            prev_stb = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) check("stb_pulse", m_stb, 0);
            if (m_stb && !prev_stb) begin
                check("expected_pending", sb.size() != 0, 1);
                if (sb.size() != 0) check("latency", cyc - sb[0].acc, W);
            end
            if (m_stb && prev_stb && !prev_ack) begin
                check("hold_m_dat", m_dat, held);
                check("s_rdy_busy", s_rdy, 0);
            end
            if (m_stb && m_rdy && sb.size() != 0) begin
                e = sb.pop_front();
                check("result", m_dat, e.dat);
            end
            prev_stb = m_stb;
            prev_ack = m_stb && m_rdy;
            held     = m_dat;
        end
    end

    task automatic issue(input logic [2*W-1:0] dat, input logic [2*W-1:0] expv);
        int g = 0;
        @(negedge clk);
        s_stb = 1'b1;
        s_dat = dat;
        while (!s_rdy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("accept_timeout", g, 0);
        else sb.push_back('{dat: expv, acc: cyc + 1});
        @(negedge clk);
        s_stb = 1'b0;
        s_dat = (2*W)'($urandom);
    endtask

    task automatic stream(input int n, input bit rand_rdy);
        int sent = 0;
        int g    = 0;
        int last = -1;
        while (sent < n && g < n * 40) begin
            @(negedge clk);
            g++;
            m_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            s_stb = 1'b1;
            s_dat = {rand_op(), rand_op()};
            if (s_rdy) begin
                sb.push_back('{dat: model(s_dat), acc: cyc + 1});
                if (!rand_rdy && last >= 0) check("spacing", cyc + 1 - last, W + 2);
                last = cyc + 1;
                sent++;
            end
        end
        if (sent < n) check("stream_timeout", sent, n);
        @(negedge clk);
        s_stb = 1'b0;
        m_rdy = 1'b1;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    logic [2*W-1:0] dv[7] = '{16'h0764, 16'h079C, 16'hF964, 16'hF99C, 16'h0005, 16'hFF80, 16'h0180};
    logic [2*W-1:0] ev[7] = '{16'h020E, 16'hFEF2, 16'h02F2, 16'hFE0E, 16'h05FF, 16'h0080, 16'h0080};

    initial begin
        int g;
        rst   = 1'b1;
        s_stb = 1'b0;
        s_dat = '0;
        m_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_rdy", s_rdy, 0);
        check("rst_m_stb", m_stb, 0);
        check("rst_m_dat", m_dat, 0);
        rst = 1'b0;
        @(negedge clk);
        check("s_rdy_after_rst", s_rdy, 1);

        m_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(dv[i], ev[i]);
            drain();
        end

        // Backpressure: result must sit still while the sink stalls.
        m_rdy = 1'b0;
        issue(16'h0764, 16'h020E);
        g = 0;
        while (!m_stb && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("bp_stb_timeout", g, 0);
        repeat (5) begin
            @(negedge clk);
            s_stb = 1'b1;
            s_dat = (2*W)'($urandom);
            check("bp_m_stb", m_stb, 1);
        end
        s_stb = 1'b0;
        m_rdy = 1'b1;
        @(negedge clk);
        check("s_rdy_after_ack", s_rdy, 1);
        drain();

        stream(20, 1'b0);
        drain();
        stream(30, 1'b1);
        drain();

        // Reset during CALC step 4 of 100/7 must drop that operation.
        @(negedge clk);
        s_stb = 1'b1;
        s_dat = 16'h0764;
        g = 0;
        while (!s_rdy && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        s_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_rdy", s_rdy, 0);
        check("midrst_m_stb", m_stb, 0);
        check("midrst_m_dat", m_dat, 0);
        rst = 1'b0;
        @(negedge clk);
        check("s_rdy_after_midrst", s_rdy, 1);
        repeat (20) @(negedge clk);
        issue(16'h0209, 16'h0104);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
